// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
//   Turns a pipeline load (byte address + RISC-V load funct3) into one or two
//   word-aligned memory reads, then shifts, truncates and sign/zero-extends
//   the returned data.
//   A load that crosses a word boundary is either split into two reads
//   (MISALIGN_EN=1) or rejected with an error (MISALIGN_EN=0).
//   Illegal funct3 encodings are always rejected.
//
// Parameters
//   XLEN        : data/address width, 32 or 64
//   MISALIGN_EN : 1 = split boundary-crossing loads, 0 = flag them as errors
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   ld_valid / ld_ready   : request handshake; ready only while idle
//   ld_addr, ld_funct3    : load byte address and load type
//   mem_req, mem_addr     : word-aligned read request, held until mem_rvalid
//   mem_rvalid, mem_rdata : read response
//   ld_done               : one-cycle completion pulse
//   ld_data, ld_err       : result and error flag, held until the next done
// ---------------------------------------------------------------------------
module load_align_unit #(
  parameter int unsigned XLEN        = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            ld_done,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_err
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_e;

  state_e            state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic              ld_done_q, ld_done_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              ld_err_q, ld_err_d;
  logic [XLEN-1:0]   word0_q, word0_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              cross_q, cross_d;

  // Request decode
  logic [OFFW-1:0]   req_off;
  logic [3:0]        req_size;
  logic              req_cross;
  logic              req_illegal;

  always_comb begin
    req_off     = ld_addr[OFFW-1:0];
    req_size    = 4'd1 << ld_funct3[1:0];
    req_cross   = (32'(req_off) + 32'(req_size)) > BYTES;
    req_illegal = (ld_funct3 == 3'b111) ||
                  ((XLEN == 32) && ((ld_funct3 == 3'b011) || (ld_funct3 == 3'b110)));
  end

  // Result formation. The word arriving this cycle is used directly so the
  // result can be registered on the same edge that enters DONE; in RD1 the
  // low word comes from the captured word0.
  logic [XLEN-1:0]   lo_w, hi_w, result;
  logic [2*XLEN-1:0] shifted;
  logic              sign_bit;
  int unsigned       nbits;

  always_comb begin
    lo_w    = (state_q == RD1) ? word0_q : mem_rdata;
    hi_w    = (state_q == RD1) ? mem_rdata : '0;
    shifted = {hi_w, lo_w} >> {off_q, 3'b000};
    nbits   = 32'd8 << f3_q[1:0];
    case (f3_q[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[63];
    endcase
    result = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? shifted[i] : (sign_bit & ~f3_q[2]);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ld_ready_d = ld_ready_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ld_done_d  = 1'b0;
    ld_data_d  = ld_data_q;
    ld_err_d   = ld_err_q;
    word0_d    = word0_q;
    off_d      = off_q;
    f3_d       = f3_q;
    cross_d    = cross_q;

    case (state_q)
      IDLE: begin
        if (ld_valid && ld_ready_q) begin
          off_d      = req_off;
          f3_d       = ld_funct3;
          cross_d    = req_cross;
          ld_ready_d = 1'b0;
          if (req_illegal || (req_cross && !MISALIGN_EN)) begin
            state_d   = DONE;
            ld_done_d = 1'b1;
            ld_err_d  = 1'b1;
            ld_data_d = '0;
          end else begin
            state_d    = RD0;
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          end
        end
      end
      RD0: begin
        if (mem_rvalid) begin
          word0_d = mem_rdata;
          if (cross_q) begin
            state_d    = RD1;
            mem_addr_d = mem_addr_q + XLEN'(BYTES);
          end else begin
            state_d   = DONE;
            mem_req_d = 1'b0;
            ld_done_d = 1'b1;
            ld_data_d = result;
            ld_err_d  = 1'b0;
          end
        end
      end
      RD1: begin
        if (mem_rvalid) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          ld_done_d = 1'b1;
          ld_data_d = result;
          ld_err_d  = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        ld_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_ready_q <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ld_done_q  <= 1'b0;
      ld_data_q  <= '0;
      ld_err_q   <= 1'b0;
      word0_q    <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      cross_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ld_done_q  <= ld_done_d;
      ld_data_q  <= ld_data_d;
      ld_err_q   <= ld_err_d;
      word0_q    <= word0_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      cross_q    <= cross_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ld_done  = ld_done_q;
  assign ld_data  = ld_data_q;
  assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// ---------------------------------------------------------------------------
// tb_load_align_unit
//   Directed bench for load_align_unit. Three instances: XLEN=32 with split
//   misaligned loads, XLEN=32 with misaligned loads flagged as errors, and
//   XLEN=64. Inputs are driven and outputs sampled 1 time unit after each
//   rising clock edge.
// ---------------------------------------------------------------------------
module tb_load_align_unit;

  logic clk;
  logic rst_n;

  // Shared 32-bit stimulus, separate request valids
  logic        v32, v32e;
  logic [31:0] a32;
  logic [2:0]  f32;
  logic        rv32;
  logic [31:0] rd32;

  logic        r_a, mq_a, dn_a, er_a;
  logic [31:0] ma_a, dt_a;
  logic        r_e, mq_e, dn_e, er_e;
  logic [31:0] ma_e, dt_e;

  logic        v64;
  logic [63:0] a64;
  logic [2:0]  f64;
  logic        rv64;
  logic [63:0] rd64;
  logic        r64, mq64, dn64, er64;
  logic [63:0] ma64, dt64;

  int total = 0;
  int bad   = 0;

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .ld_valid(v32), .ld_ready(r_a),
    .ld_addr(a32), .ld_funct3(f32), .mem_req(mq_a), .mem_addr(ma_a),
    .mem_rvalid(rv32), .mem_rdata(rd32), .ld_done(dn_a), .ld_data(dt_a),
    .ld_err(er_a));

  load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u32e (
    .clk(clk), .rst_n(rst_n), .ld_valid(v32e), .ld_ready(r_e),
    .ld_addr(a32), .ld_funct3(f32), .mem_req(mq_e), .mem_addr(ma_e),
    .mem_rvalid(rv32), .mem_rdata(rd32), .ld_done(dn_e), .ld_data(dt_e),
    .ld_err(er_e));

  load_align_unit #(.XLEN(64), .MISALIGN_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .ld_valid(v64), .ld_ready(r64),
    .ld_addr(a64), .ld_funct3(f64), .mem_req(mq64), .mem_addr(ma64),
    .mem_rvalid(rv64), .mem_rdata(rd64), .ld_done(dn64), .ld_data(dt64),
    .ld_err(er64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (r_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", r_a); end
    total++; if (mq_a !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h want=0", mq_a); end
    total++; if (ma_a !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", ma_a); end
    total++; if (dn_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h want=0", dn_a); end
    total++; if (er_a !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h want=0", er_a); end
    total++; if (dt_a !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dt_a); end
    total++; if (r64 !== 1'b1) begin bad++; $display("FAIL reset_ready64 got=%0h want=1", r64); end
    rst_n = 1'b1;
    step();
  endtask

  // Byte load at 0x102 from word 0x00800000
  task automatic test_byte(input logic [2:0] f3, input logic [31:0] exp, input string nm);
    a32 = 32'h0000_0102; f32 = f3; v32 = 1'b1;
    step();
    v32 = 1'b0;
    total++; if (dn_a !== 1'b0) begin bad++; $display("FAIL %s_early_done got=%0h want=0", nm, dn_a); end
    total++; if (mq_a !== 1'b1) begin bad++; $display("FAIL %s_mem_req got=%0h want=1", nm, mq_a); end
    total++; if (ma_a !== 32'h0000_0100) begin bad++; $display("FAIL %s_mem_addr got=%h want=00000100", nm, ma_a); end
    total++; if (r_a !== 1'b0) begin bad++; $display("FAIL %s_busy_ready got=%0h want=0", nm, r_a); end
    rv32 = 1'b1; rd32 = 32'h0080_0000;
    step();
    rv32 = 1'b0; rd32 = 32'hFFFF_FFFF;
    total++; if (dn_a !== 1'b1) begin bad++; $display("FAIL %s_done got=%0h want=1", nm, dn_a); end
    total++; if (dt_a !== exp) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, dt_a, exp); end
    total++; if (er_a !== 1'b0) begin bad++; $display("FAIL %s_err got=%0h want=0", nm, er_a); end
    total++; if (mq_a !== 1'b0) begin bad++; $display("FAIL %s_req_drop got=%0h want=0", nm, mq_a); end
    step();
    total++; if (dn_a !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%0h want=0", nm, dn_a); end
    total++; if (r_a !== 1'b1) begin bad++; $display("FAIL %s_ready_back got=%0h want=1", nm, r_a); end
    total++; if (dt_a !== exp) begin bad++; $display("FAIL %s_data_hold got=%h want=%h", nm, dt_a, exp); end
  endtask

  // LH at 0x103 split over 0x100/0x104; inputs changed after accept
  task automatic test_cross();
    a32 = 32'h0000_0103; f32 = 3'b001; v32 = 1'b1;
    step();
    v32 = 1'b0; a32 = 32'h0; f32 = 3'b111;
    total++; if (ma_a !== 32'h0000_0100) begin bad++; $display("FAIL cross_addr0 got=%h want=00000100", ma_a); end
    rv32 = 1'b1; rd32 = 32'hAABB_CCDD;
    step();
    total++; if (mq_a !== 1'b1) begin bad++; $display("FAIL cross_req1 got=%0h want=1", mq_a); end
    total++; if (ma_a !== 32'h0000_0104) begin bad++; $display("FAIL cross_addr1 got=%h want=00000104", ma_a); end
    total++; if (dn_a !== 1'b0) begin bad++; $display("FAIL cross_early_done got=%0h want=0", dn_a); end
    rd32 = 32'h1122_3344;
    step();
    rv32 = 1'b0;
    total++; if (dn_a !== 1'b1) begin bad++; $display("FAIL cross_done got=%0h want=1", dn_a); end
    total++; if (dt_a !== 32'h0000_44AA) begin bad++; $display("FAIL cross_data got=%h want=000044aa", dt_a); end
    total++; if (er_a !== 1'b0) begin bad++; $display("FAIL cross_err got=%0h want=0", er_a); end
    total++; if (mq_a !== 1'b0) begin bad++; $display("FAIL cross_req_drop got=%0h want=0", mq_a); end
    step();
  endtask

  // LW at 0xFFFFFFFE: second read wraps to address 0
  task automatic test_wrap();
    a32 = 32'hFFFF_FFFE; f32 = 3'b010; v32 = 1'b1;
    step();
    v32 = 1'b0;
    total++; if (ma_a !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", ma_a); end
    rv32 = 1'b1; rd32 = 32'h1234_FFFF;
    step();
    total++; if (ma_a !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr1 got=%h want=00000000", ma_a); end
    rd32 = 32'h0000_8765;
    step();
    rv32 = 1'b0;
    total++; if (dn_a !== 1'b1) begin bad++; $display("FAIL wrap_done got=%0h want=1", dn_a); end
    total++; if (dt_a !== 32'h8765_1234) begin bad++; $display("FAIL wrap_data got=%h want=87651234", dt_a); end
    step();
  endtask

  task automatic test_error();
    // Legal load on the non-splitting instance, so the error result is visible
    a32 = 32'h0000_0200; f32 = 3'b010; v32e = 1'b1;
    step();
    v32e = 1'b0;
    rv32 = 1'b1; rd32 = 32'hDEAD_BEEF;
    step();
    rv32 = 1'b0;
    total++; if (dt_e !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_pre_data got=%h want=deadbeef", dt_e); end
    step();
    // Crossing LW with splitting disabled
    a32 = 32'h0000_0201; f32 = 3'b010; v32e = 1'b1;
    step();
    v32e = 1'b0;
    total++; if (dn_e !== 1'b1) begin bad++; $display("FAIL err_mis_done got=%0h want=1", dn_e); end
    total++; if (er_e !== 1'b1) begin bad++; $display("FAIL err_mis_err got=%0h want=1", er_e); end
    total++; if (dt_e !== 32'h0) begin bad++; $display("FAIL err_mis_data got=%h want=0", dt_e); end
    total++; if (mq_e !== 1'b0) begin bad++; $display("FAIL err_mis_req got=%0h want=0", mq_e); end
    step();
    total++; if (dn_e !== 1'b0) begin bad++; $display("FAIL err_mis_pulse got=%0h want=0", dn_e); end
    total++; if (er_e !== 1'b1) begin bad++; $display("FAIL err_mis_hold got=%0h want=1", er_e); end
    total++; if (r_e !== 1'b1) begin bad++; $display("FAIL err_mis_ready got=%0h want=1", r_e); end
    // funct3=111 on the splitting instance (previous data 0x87651234)
    a32 = 32'h0000_0100; f32 = 3'b111; v32 = 1'b1;
    step();
    v32 = 1'b0;
    total++; if (dn_a !== 1'b1) begin bad++; $display("FAIL err_f7_done got=%0h want=1", dn_a); end
    total++; if (er_a !== 1'b1) begin bad++; $display("FAIL err_f7_err got=%0h want=1", er_a); end
    total++; if (dt_a !== 32'h0) begin bad++; $display("FAIL err_f7_data got=%h want=0", dt_a); end
    total++; if (mq_a !== 1'b0) begin bad++; $display("FAIL err_f7_req got=%0h want=0", mq_a); end
    step();
    // LD is illegal at XLEN=32
    a32 = 32'h0000_0100; f32 = 3'b011; v32 = 1'b1;
    step();
    v32 = 1'b0;
    total++; if ((dn_a !== 1'b1) || (er_a !== 1'b1)) begin bad++; $display("FAIL err_ld32 got done=%0h err=%0h want done=1 err=1", dn_a, er_a); end
    step();
  endtask

  task automatic test_x64();
    a64 = 64'h4; f64 = 3'b110; v64 = 1'b1;
    step();
    v64 = 1'b0;
    total++; if (ma64 !== 64'h0) begin bad++; $display("FAIL x64_addr got=%h want=0", ma64); end
    rv64 = 1'b1; rd64 = 64'hF000_0000_0000_0000;
    step();
    rv64 = 1'b0; rd64 = 64'h1234_5678_9ABC_DEF0;
    total++; if (dt64 !== 64'h0000_0000_F000_0000) begin bad++; $display("FAIL x64_lwu got=%h want=00000000f0000000", dt64); end
    step();
    // LW with three wait cycles: done at T+5
    a64 = 64'h4; f64 = 3'b010; v64 = 1'b1;
    step();
    v64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ((mq64 !== 1'b1) || (dn64 !== 1'b0)) begin bad++; $display("FAIL x64_wait%0d got req=%0h done=%0h want req=1 done=0", i, mq64, dn64); end
      step();
    end
    rv64 = 1'b1; rd64 = 64'hF000_0000_0000_0000;
    step();
    rv64 = 1'b0;
    total++; if (dn64 !== 1'b1) begin bad++; $display("FAIL x64_wait_done got=%0h want=1", dn64); end
    total++; if (dt64 !== 64'hFFFF_FFFF_F000_0000) begin bad++; $display("FAIL x64_lw got=%h want=fffffffff0000000", dt64); end
    step();
  endtask

  task automatic test_reset_mid();
    a32 = 32'h0000_0103; f32 = 3'b001; v32 = 1'b1;
    step();
    v32 = 1'b0;
    rv32 = 1'b1; rd32 = 32'hAABB_CCDD;
    step();
    rv32 = 1'b0;
    total++; if ((mq_a !== 1'b1) || (ma_a !== 32'h0000_0104)) begin bad++; $display("FAIL rmid_rd1 got req=%0h addr=%h want req=1 addr=00000104", mq_a, ma_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mq_a !== 1'b0) begin bad++; $display("FAIL rmid_req_drop got=%0h want=0", mq_a); end
    total++; if (dt_a !== 32'h0) begin bad++; $display("FAIL rmid_data_clr got=%h want=0", dt_a); end
    rv32 = 1'b1; rd32 = 32'h1122_3344;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ((dn_a !== 1'b0) || (mq_a !== 1'b0) || (r_a !== 1'b1)) begin bad++; $display("FAIL rmid_after%0d got done=%0h req=%0h ready=%0h want 0 0 1", i, dn_a, mq_a, r_a); end
    end
    rv32 = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    v32 = 1'b0; v32e = 1'b0; a32 = '0; f32 = '0; rv32 = 1'b0; rd32 = '0;
    v64 = 1'b0; a64 = '0; f64 = '0; rv64 = 1'b0; rd64 = '0;
    test_reset();
    test_byte(3'b000, 32'hFFFF_FF80, "lb");
    test_byte(3'b100, 32'h0000_0080, "lbu");
    test_cross();
    test_wrap();
    test_error();
    test_x64();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/address width; legal values are 32 and 64; BYTES = XLEN/8, OFFW = log2(BYTES).
REQ-002 Parameter MISALIGN_EN, default 1, SHALL select behaviour: 1 = split boundary-crossing loads into two accesses; 0 = flag them as errors.
REQ-003 clock  in  1  the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ld_valid  in  1  load request from the pipeline.
REQ-006 ld_ready  out  1  unit can accept a request.
REQ-007 ld_addr  in  XLEN  byte address of the load.
REQ-008 ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-009 mem_req  out  1  memory read request, held until a response arrives.
REQ-010 mem_addr  out  XLEN  BYTES-aligned word address; low OFFW bits are always 0.
REQ-011 mem_rvalid  in  1  mem_rdata is valid this cycle.
REQ-012 mem_rdata  in  XLEN  returned memory word.
REQ-013 ld_done  out  1  one-cycle completion pulse.
REQ-014 ld_data  out  XLEN  extended load result.
REQ-015 ld_err  out  1  the completing load is illegal or misaligned; qualified by ld_done.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD0, RD1, DONE; ld_ready = 1 only in IDLE.
REQ-017 A request SHALL be accepted on a cycle with ld_valid && ld_ready; the unit then latches addr and funct3, and later input changes are ignored.
REQ-018 Access size SHALL be 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11; funct3[2]=1 selects zero extension, otherwise sign extension.
REQ-019 funct3 = 111 SHALL be illegal; with XLEN=32, 011 and 110 SHALL also be illegal.
REQ-020 Let offset = addr[OFFW-1:0]; the load crosses a word boundary when offset + size > BYTES.
REQ-021 An illegal load, or a crossing load with MISALIGN_EN=0, SHALL go IDLE->DONE with no mem_req; the result is ld_err=1 and ld_data=0.
REQ-022 Otherwise the FSM SHALL go IDLE->RD0 with mem_req=1 and mem_addr = addr with its low OFFW bits cleared.
REQ-023 In RD0, mem_rvalid=1 SHALL capture word0; the next state is RD1 if the load crosses a boundary, else DONE.
REQ-024 In RD1, mem_req SHALL stay 1 with mem_addr = word0 address + BYTES, wrapping modulo 2^XLEN; mem_rvalid=1 captures word1 and moves to DONE.
REQ-025 mem_rvalid SHALL be ignored while mem_req=0; wait cycles in RD0/RD1 are unbounded.
REQ-026 Result SHALL be ({word1,word0} >> 8*offset), truncated to size bytes and extended to XLEN; word1 = 0 for non-crossing loads.
REQ-027 DONE SHALL assert ld_done=1 for exactly one cycle, then return to IDLE; ld_err=0 on legal loads.
REQ-028 ld_data and ld_err SHALL hold their values until the next DONE.
REQ-029 Minimum latency SHALL be: accept at cycle T, ld_done at T+2 (aligned, zero-wait), T+3 (crossing), T+1 (error).
REQ-030 mem_req SHALL deassert in the cycle after the final mem_rvalid (the DONE cycle).

Reset
REQ-031 When reset=0, asynchronously: state=IDLE, ld_ready=1, mem_req=0, mem_addr=0, ld_done=0, ld_err=0, ld_data=0, and captured words cleared.
REQ-032 Reset mid-operation (RD0/RD1/DONE) SHALL abort the load without ld_done; any later mem_rvalid SHALL be ignored per REQ-025.

Verification
REQ-033 XLEN=32, LB at 0x102, word 0x00800000 -> ld_data=0xFFFFFF80; the same access as LBU -> 0x00000080; ld_done exactly 2 cycles after accept.
REQ-034 XLEN=32, MISALIGN_EN=1, LH at 0x103, word(0x100)=0xAABBCCDD, word(0x104)=0x11223344 -> mem_addr 0x100 then 0x104, ld_data=0x000044AA, ld_err=0.
REQ-035 XLEN=32, LW at 0xFFFFFFFE, word(0xFFFFFFFC)=0x1234FFFF, word(0)=0x00008765 -> second mem_addr=0x00000000, ld_data=0x87651234.
REQ-036 MISALIGN_EN=0, LW at 0x201 -> no mem_req, ld_done at T+1 with ld_err=1 and ld_data=0; funct3=111 at any address gives the same response.
REQ-037 XLEN=64, LWU at 0x4, word(0x0)=0xF0000000_00000000 -> ld_data=0x00000000_F0000000; as LW -> 0xFFFFFFFF_F0000000; 3 wait cycles on mem_rvalid stretch the latency to T+5.
REQ-038 reset=0 asserted in RD1, followed by a stray mem_rvalid -> mem_req drops immediately, no ld_done, ld_ready=1 after reset releases.
